// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU: instruction width, field positions
// and the pre-split instruction layout.
package cpu_pkg;

  localparam int IW       = 19;
  localparam int CLS_MSB  = 18;
  localparam int CODE_MSB = 16;
  localparam int IMM_MSB  = 13;
  localparam int SEL_MSB  = 1;

  typedef struct packed {
    logic [CLS_MSB-CODE_MSB-1:0] cls;
    logic [CODE_MSB-IMM_MSB-1:0] code;
    logic [IMM_MSB-SEL_MSB-1:0]  imm;
    logic [SEL_MSB:0]            sel;
  } instr_t;

endpackage

// File: rtl/imq_ptr_ctrl.sv
// Pointer, occupancy and overflow bookkeeping for the instruction fetch queue.
// Decides push acceptance and pop; the storage array lives in the parent.
module imq_ptr_ctrl #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_push_req,
  input  logic          i_flush,
  input  logic          i_ready,
  output logic          o_wr_en,
  output logic [PW-1:0] o_wr_ptr,
  output logic [PW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ovf,
  output logic          o_valid
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_pop;
  logic          w_push_acc;
  logic          w_push_rej;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_valid = i_en & ~o_empty;

  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign w_pop      = o_valid & i_ready;
  assign w_push_acc = i_push_req & (~o_full | w_pop);
  assign w_push_rej = i_push_req & o_full & ~w_pop;
  assign o_wr_en    = w_push_acc & ~i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_acc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_rej) r_ovf <= 1'b1;
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/im_fetch_queue.sv
// Instruction-memory load receiver and in-order fetch queue with pre-split fields.
// Define IMQ_WE_EDGE_EN to write one word per rising edge of we_IM instead of per cycle.
module im_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we_IM,
  input  logic [IW-1:0] codein,
  input  logic          flush,
  input  logic          instr_ready,
  output logic          instr_valid,
  output logic [IW-1:0] instr_out,
  output logic [1:0]    op_cls,
  output logic [2:0]    op_code,
  output logic [11:0]   op_imm,
  output logic [1:0]    op_sel,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ovf
);

  localparam int PW = $clog2(DEPTH);

  logic          w_wr_strobe;
  logic          w_push_req;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  instr_t        w_instr;
  logic [IW-1:0] r_mem [DEPTH];

`ifdef IMQ_WE_EDGE_EN
  logic r_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_we_q <= 1'b0;
    else        r_we_q <= we_IM;
  end

  assign w_wr_strobe = we_IM & ~r_we_q;
`else
  assign w_wr_strobe = we_IM;
`endif

  assign w_push_req = en & w_wr_strobe;

  imq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .CW    (CW),
    .PW    (PW)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (en),
    .i_push_req (w_push_req),
    .i_flush    (flush),
    .i_ready    (instr_ready),
    .o_wr_en    (w_wr_en),
    .o_wr_ptr   (w_wr_ptr),
    .o_rd_ptr   (w_rd_ptr),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty),
    .o_ovf      (ovf),
    .o_valid    (instr_valid)
  );

  // Cleared on reset so the head reads 0 while empty; flush leaves contents alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[w_wr_ptr] <= codein;
    end
  end

  assign instr_out = r_mem[w_rd_ptr];
  assign w_instr   = instr_t'(instr_out);
  assign op_cls    = w_instr.cls;
  assign op_code   = w_instr.code;
  assign op_imm    = w_instr.imm;
  assign op_sel    = w_instr.sel;

endmodule

// File: tb/tb_im_fetch_queue.sv
// Directed bench for im_fetch_queue; expectations follow IMQ_WE_EDGE_EN when defined.
module tb_im_fetch_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          we_IM;
  logic [18:0]   codein;
  logic          flush;
  logic          instr_ready;
  logic          instr_valid;
  logic [18:0]   instr_out;
  logic [1:0]    op_cls;
  logic [2:0]    op_code;
  logic [11:0]   op_imm;
  logic [1:0]    op_sel;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  im_fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .we_IM       (we_IM),
    .codein      (codein),
    .flush       (flush),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .op_cls      (op_cls),
    .op_code     (op_code),
    .op_imm      (op_imm),
    .op_sel      (op_sel),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [18:0] w);
    we_IM  = 1'b1;
    codein = w;
    step();
    we_IM  = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; we_IM = 1'b0; codein = '0; flush = 1'b0; instr_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_out",   32'(instr_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single word, field split
    en = 1'b1; we_IM = 1'b1; codein = 19'b00_100_000000000001_11;
    step();
    we_IM = 1'b0;
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_cls",   32'(op_cls),  32'd0);
    chk("t1_code",  32'(op_code), 32'd4);
    chk("t1_imm",   32'(op_imm),  32'd1);
    chk("t1_sel",   32'(op_sel),  32'd3);
    chk("t1_count", 32'(count),   32'd1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t1_empty", 32'(empty), 32'd1);

    // fill past depth
    for (int i = 1; i <= 9; i++) begin
      push(19'h100 + 19'(i));
      if (i == 8) begin
        chk("t2_full8",  32'(full),  32'd1);
        chk("t2_count8", 32'(count), 32'd8);
        chk("t2_ovf8",   32'(ovf),   32'd0);
      end
    end
    chk("t2_ovf9",   32'(ovf),   32'd1);
    chk("t2_count9", 32'(count), 32'd8);
    instr_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_pop_valid", 32'(instr_valid), 32'd1);
      chk("t2_pop_word",  32'(instr_out),   32'h100 + 32'(i));
      step();
    end
    instr_ready = 1'b0;
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_valid", 32'(instr_valid), 32'd0);
    chk("t2_ovf_sticky", 32'(ovf), 32'd1);

    // flush mid-stream with ovf set
    for (int i = 1; i <= 5; i++) push(19'h500 + 19'(i));
    chk("t6_count5", 32'(count), 32'd5);
    chk("t6_ovf1",   32'(ovf),   32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_ovf",   32'(ovf),   32'd0);
    chk("t6_flush_valid", 32'(instr_valid), 32'd0);

    // full queue, simultaneous push and pop
    for (int i = 0; i < 8; i++) push(19'h200 + 19'(i));
    chk("t3_full", 32'(full), 32'd1);
    instr_ready = 1'b1; we_IM = 1'b1; codein = 19'h2AA;
    step();
    we_IM = 1'b0; instr_ready = 1'b0;
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_ovf",   32'(ovf),   32'd0);
    chk("t3_full2", 32'(full),  32'd1);
    step();
    instr_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      chk("t3_pop_word", 32'(instr_out), 32'h200 + 32'(i));
      step();
    end
    chk("t3_last_word", 32'(instr_out), 32'h2AA);
    step();
    instr_ready = 1'b0;
    chk("t3_empty", 32'(empty), 32'd1);

    // strobe held for three cycles
    we_IM = 1'b1; codein = 19'h333;
    step(); step(); step();
    we_IM = 1'b0;
    step();
`ifdef IMQ_WE_EDGE_EN
    chk("t4_count_edge", 32'(count), 32'd1);
`else
    chk("t4_count_level", 32'(count), 32'd3);
`endif
    chk("t4_word", 32'(instr_out), 32'h333);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_flushed", 32'(empty), 32'd1);

    // enable gating holds contents
    push(19'h401);
    push(19'h402);
    en = 1'b0;
    #1;
    chk("t5_valid_off", 32'(instr_valid), 32'd0);
    push(19'h403);
    instr_ready = 1'b1;
    step();
    chk("t5_count_held", 32'(count), 32'd2);
    chk("t5_valid_off2", 32'(instr_valid), 32'd0);
    en = 1'b1;
    #1;
    chk("t5_valid_on", 32'(instr_valid), 32'd1);
    chk("t5_word1", 32'(instr_out), 32'h401);
    step();
    chk("t5_word2", 32'(instr_out), 32'h402);
    step();
    instr_ready = 1'b0;
    chk("t5_empty", 32'(empty), 32'd1);

    // async reset mid-stream
    for (int i = 1; i <= 5; i++) push(19'h600 + 19'(i));
    chk("t7_count5", 32'(count), 32'd5);
    chk("t7_valid_pre", 32'(instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_valid_async", 32'(instr_valid), 32'd0);
    chk("t7_count_async", 32'(count), 32'd0);
    chk("t7_out_cleared", 32'(instr_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("t7_empty_after", 32'(empty), 32'd1);
    chk("t7_ovf_after",   32'(ovf),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_fetch_queue.md
# im_fetch_queue

Instruction-memory write receiver and fetch queue for the 19-bit CPU. Accepts instruction words pushed through the `we_IM`/`codein` load port, buffers them in order, and presents them one at a time to the CPU decode stage over a valid/ready handshake, with the instruction fields pre-split. It is the consumer end of the instruction-load interface driven by the host or bench.

## Interface
- `IW`, 19: instruction word width.
- `DEPTH`, 8: queue entries; power of two, at least 2.
- `CW`, `$clog2(DEPTH+1)`: occupancy counter width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable. When 0, writes are ignored, `instr_valid` is forced to 0, and contents are held.
- `we_IM`  in  1  instruction write strobe.
- `codein`  in  IW  instruction word; sampled with `we_IM`.
- `flush`  in  1  synchronous clear of the queue and `ovf`.
- `instr_ready`  in  1  the decoder accepts the head word.
- `instr_valid`  out  1  the head word is available.
- `instr_out`  out  IW  head word.
- `op_cls`  out  2  `instr_out[18:17]`.
- `op_code`  out  3  `instr_out[16:14]`.
- `op_imm`  out  12  `instr_out[13:2]`.
- `op_sel`  out  2  `instr_out[1:0]`.
- `count`  out  CW  number of stored words.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `ovf`  out  1  sticky flag: a write was dropped.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each `$clog2(DEPTH)` bits. Both pointers wrap modulo DEPTH.
- Push request (`push_req`): `en & wr_strobe`. `wr_strobe` is defined under Configuration.
- Pop: `pop = instr_valid & instr_ready`. On a pop, `rd_ptr` increments and `count` decrements.
- Push accepted when `push_req & (!full | pop)`. On an accepted push, `codein` is written at `wr_ptr` and `wr_ptr` increments.
- Push rejected when `push_req & full & !pop`. The word is dropped and `ovf` is set to 1 on the next edge.
- Simultaneous accepted push and pop: `count` is unchanged, both pointers advance. This also applies when the queue is full.
- Pop while empty cannot occur, because `instr_valid` is 0.
- `instr_valid = en & !empty`.
- `instr_out = mem[rd_ptr]`, read combinationally. The field outputs are pure slices of `instr_out`.
- `flush` has priority over push and pop. It sets pointers, `count` and `ovf` to 0. Memory contents are not cleared.
- `en` = 0 does not clear state. Re-asserting `en` resumes with the stored words in order.

## Timing
- Reset (async assert, released synchronously by the system): pointers, `count` and `ovf` are 0, `empty` = 1, `full` = 0, `instr_valid` = 0. `instr_out` and the field outputs are don't-care while empty; the implementation drives 0 from a reset-cleared memory.
- Write-to-valid latency is 1 edge: a push accepted at edge N gives `instr_valid` = 1 and the word on `instr_out` after edge N.
- Throughput is one push and one pop per cycle.
- When `rst_n` is asserted mid-operation, all entries are lost immediately and no partial state survives.
- `ovf` clears only on `rst_n` or `flush`.

## Configuration
- Macro `IMQ_WE_EDGE_EN`.
  - Defined: `wr_strobe = we_IM & !we_IM_q`, where `we_IM_q` is a register reset to 0. A strobe held high for several cycles writes exactly one word.
  - Undefined: `wr_strobe = we_IM`. One word is written per cycle the strobe is high, and `we_IM_q` is not built.

## Structure
- Shared package `cpu_pkg` holds:
  - `IW`;
  - the field position constants (`CLS_MSB` = 18, `CODE_MSB` = 16, `IMM_MSB` = 13, `SEL_MSB` = 1);
  - the `instr_t` packed struct with fields cls, code, imm, sel.
- One sub-module, `imq_ptr_ctrl`, owns the pointers, `count`, `full`/`empty` and `ovf`. The storage array and the field slicing stay in the top level.

## Test plan
- Reset, then `en` = 1 and one `we_IM` pulse with `codein` = `19'b00_100_000000000001_11` → one edge later: `instr_valid` = 1, `op_cls` = 0, `op_code` = 4, `op_imm` = 1, `op_sel` = 3, `count` = 1.
- `instr_ready` = 0, push 9 words with DEPTH = 8 → `full` = 1 after 8 pushes, 9th word dropped, `ovf` = 1. Then `instr_ready` = 1 → words 1–8 pop in order, `empty` = 1.
- Queue full, push and pop in the same cycle → `count` stays 8, `ovf` stays 0, and the new word is last out.
- `we_IM` held high for 3 cycles → with `IMQ_WE_EDGE_EN`, `count` = 1; without it, `count` = 3.
- `en` = 0 with 2 words stored → `instr_valid` = 0 and further pushes are ignored. `en` = 1 → the same 2 words pop in order.
- Both mid-stream events on 5 stored words:
  - `flush` with `ovf` = 1 → `count` = 0, `ovf` = 0.
  - `rst_n` pulsed low → `instr_valid` = 0 immediately, without waiting for a clock edge.
